// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime with prescaler, mtimecmp, msip; one-cycle registered reads.
// Optional CLINT_SNAPSHOT_EN: a read of mtime lo latches mtime hi into a shadow returned by hi reads.
module clint_timer #(
  parameter int unsigned TickDiv     = 1,
  parameter int unsigned DecodeWidth = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        timer_irq_o,
  output logic        soft_irq_o
);

  localparam logic [15:0]            TickLast    = 16'(TickDiv - 1);
  localparam logic [DecodeWidth-1:0] OffMsip     = DecodeWidth'(16'h0000);
  localparam logic [DecodeWidth-1:0] OffCmpLo    = DecodeWidth'(16'h4000);
  localparam logic [DecodeWidth-1:0] OffCmpHi    = DecodeWidth'(16'h4004);
  localparam logic [DecodeWidth-1:0] OffMtimeLo  = DecodeWidth'(16'hBFF8);
  localparam logic [DecodeWidth-1:0] OffMtimeHi  = DecodeWidth'(16'hBFFC);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic [31:0] mtime_hi_rd;

  logic [DecodeWidth-1:0] off;
  logic                   wr, rd, tick;
  logic                   unused_addr;

  assign off         = {addr_i[DecodeWidth-1:2], 2'b00};
  assign wr          = req_i & we_i;
  assign rd          = req_i & ~we_i;
  assign tick        = (presc_q == TickLast);
  assign unused_addr = ^{addr_i[31:DecodeWidth], addr_i[1:0]};

`ifdef CLINT_SNAPSHOT_EN
  logic [31:0] shadow_q, shadow_d;

  assign mtime_hi_rd = shadow_q;

  always_comb begin
    shadow_d = shadow_q;
    if (rd && off == OffMtimeLo) shadow_d = mtime_q[63:32];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = rdata_q;
    irq_d      = (mtime_q >= mtimecmp_q);

    // A half-word write overrides the increment with no carry into the other half.
    if (wr) begin
      case (off)
        OffMsip:    msip_d             = wdata_i[0];
        OffCmpLo:   mtimecmp_d[31:0]   = wdata_i;
        OffCmpHi:   mtimecmp_d[63:32]  = wdata_i;
        OffMtimeLo: mtime_d            = {mtime_q[63:32], wdata_i};
        OffMtimeHi: mtime_d            = {wdata_i, mtime_q[31:0]};
        default:    ;
      endcase
    end

    if (rd) begin
      case (off)
        OffMsip:    rdata_d = {31'd0, msip_q};
        OffCmpLo:   rdata_d = mtimecmp_q[31:0];
        OffCmpHi:   rdata_d = mtimecmp_q[63:32];
        OffMtimeLo: rdata_d = mtime_q[31:0];
        OffMtimeHi: rdata_d = mtime_hi_rd;
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign timer_irq_o = irq_q;
  assign soft_irq_o  = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed plus random bench for clint_timer against a register-level reference model.
module tb_clint_timer;

  logic        clk, rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        tirq, sirq;
  logic        req4;
  logic [31:0] rdata4;
  logic        tirq4, sirq4;

  localparam logic [31:0] BASE = 32'h0200_0000;

  clint_timer #(.TickDiv(1), .DecodeWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .timer_irq_o(tirq), .soft_irq_o(sirq)
  );

  clint_timer #(.TickDiv(4), .DecodeWidth(16)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .we_i(1'b0), .addr_i(BASE + 32'hBFF8),
    .wdata_i(32'd0), .rdata_o(rdata4), .timer_irq_o(tirq4), .soft_irq_o(sirq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned ncomp = 0;
  int unsigned nfail = 0;
  int unsigned edges = 0;

  // Reference model of the TickDiv=1 instance: architectural register values.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_irq;
  logic [31:0] m_rdata, m_shadow;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0; m_irq = 1'b0;
    m_rdata = 32'd0; m_shadow = 32'd0;
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [15:0] o;
    o = {a[15:2], 2'b00};
    case (o)
      16'h0000: return {31'd0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mtime[31:0];
`ifdef CLINT_SNAPSHOT_EN
      16'hBFFC: return m_shadow;
`else
      16'hBFFC: return m_mtime[63:32];
`endif
      default:  return 32'd0;
    endcase
  endfunction

  // One clock: drive a bus op, advance the model to the post-edge state, sample #1 after the edge.
  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] nt;
    logic [15:0] o;
    req = r; we = w; addr = a; wdata = d;
    o = {a[15:2], 2'b00};
    nt = m_mtime + 64'd1;
    if (r && w && o == 16'hBFF8) nt = {m_mtime[63:32], d};
    if (r && w && o == 16'hBFFC) nt = {d, m_mtime[31:0]};
    m_irq = (m_mtime >= m_cmp);
    if (r && !w) begin
      m_rdata = mread(a);
      if (o == 16'hBFF8) m_shadow = m_mtime[63:32];
    end
    if (r && w && o == 16'h0000) m_msip = d[0];
    if (r && w && o == 16'h4000) m_cmp[31:0] = d;
    if (r && w && o == 16'h4004) m_cmp[63:32] = d;
    m_mtime = nt;
    @(posedge clk);
    #1;
    edges++;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [15:0] off, input logic [31:0] d);
    cyc(1'b1, 1'b1, BASE + {16'd0, off}, d);
  endtask

  task automatic rd(input logic [15:0] off);
    cyc(1'b1, 1'b0, BASE + {16'd0, off}, 32'd0);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_rdata"}, {32'd0, rdata}, {32'd0, m_rdata});
    check({tag, "_tirq"}, {63'd0, tirq}, {63'd0, m_irq});
    check({tag, "_sirq"}, {63'd0, sirq}, {63'd0, m_msip});
  endtask

  initial begin
    logic [15:0] offs [7];
    offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1234, 16'h8000};
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; req4 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset");
    rst = 1'b0;
    edges = 0;

    // Reset values via reads
    rd(16'h4000); check("cmp_lo_rst", {32'd0, rdata}, 64'hFFFF_FFFF);
    rd(16'h4004); check("cmp_hi_rst", {32'd0, rdata}, 64'hFFFF_FFFF);
    check_all("after_rst_reads");

    // TickDiv=4 counting: read issued on edge 41 sees mtime after 40 edges
    while (edges < 40) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    req4 = 1'b1;
    cyc(1'b0, 1'b0, 32'd0, 32'd0);
    req4 = 1'b0;
    check("div4_count", {32'd0, rdata4}, 64'd10);

    // Compare and timer interrupt
    wr(16'hBFF8, 32'd0); wr(16'hBFFC, 32'd0);
    wr(16'h4004, 32'd0); wr(16'h4000, 32'd20);
    check_all("cmp_setup");
    for (int i = 0; i < 40 && m_mtime != 64'd20; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    check("mtime_reached20", m_mtime, 64'd20);
    check("irq_not_early", {63'd0, tirq}, 64'd0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0);
    check("irq_rise", {63'd0, tirq}, 64'd1);
    wr(16'h4000, 32'hFFFF_FFF0);
    check("irq_hold_on_wr", {63'd0, tirq}, 64'd1);
    cyc(1'b0, 1'b0, 32'd0, 32'd0);
    check("irq_fall", {63'd0, tirq}, 64'd0);

    // Carry across halves and write-vs-increment collision
    wr(16'hBFF8, 32'hFFFF_FFFF); wr(16'hBFFC, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0);
    rd(16'hBFF8); check("carry_lo", {32'd0, rdata}, 64'd0);
    rd(16'hBFFC); check("carry_hi", {32'd0, rdata}, 64'd1);
    wr(16'hBFF8, 32'd5);
    rd(16'hBFF8); check("collide_lo", {32'd0, rdata}, 64'd5);

    // Software interrupt and unmapped offsets
    wr(16'h0000, 32'h3); check("sirq_set", {63'd0, sirq}, 64'd1);
    rd(16'h0000);        check("msip_rd", {32'd0, rdata}, 64'd1);
    wr(16'h0000, 32'h0); check("sirq_clr", {63'd0, sirq}, 64'd0);
    rd(16'h1234);        check("unmapped_rd", {32'd0, rdata}, 64'd0);
    wr(16'h8000, 32'hDEAD_BEEF);
    check("unmapped_wr_rdata", {32'd0, rdata}, 64'd0);
    rd(16'h4000); check("cmp_lo_kept", {32'd0, rdata}, 64'hFFFF_FFF0);
    rd(16'h4004); check("cmp_hi_kept", {32'd0, rdata}, 64'd0);

    // Snapshot behaviour on lo-then-hi read
    wr(16'hBFFC, 32'd1); wr(16'hBFF8, 32'hFFFF_FFFF);
    rd(16'hBFF8); check("snap_lo", {32'd0, rdata}, 64'hFFFF_FFFF);
    rd(16'hBFFC);
`ifdef CLINT_SNAPSHOT_EN
    check("snap_hi", {32'd0, rdata}, 64'd1);
`else
    check("snap_hi", {32'd0, rdata}, 64'd2);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [15:0] o;
      logic [31:0] d;
      o = offs[$urandom_range(0, 6)];
      d = $urandom();
      if (o == 16'h4004 || o == 16'hBFFC) d = $urandom_range(0, 2);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          BASE + {16'd0, o} + 32'($urandom_range(0, 3)), d);
      check_all("rand");
    end

    // Asynchronous reset between edges with interrupts active
    wr(16'h4004, 32'd0); wr(16'h4000, 32'd0); wr(16'h0000, 32'd1);
    rd(16'h0000);
    cyc(1'b0, 1'b0, 32'd0, 32'd0);
    check_all("pre_arst");
    check("pre_arst_tirq_hi", {63'd0, tirq}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_tirq", {63'd0, tirq}, 64'd0);
    check("arst_sirq", {63'd0, sirq}, 64'd0);
    check("arst_rdata", {32'd0, rdata}, 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    rd(16'h4004); check("post_arst_cmp_hi", {32'd0, rdata}, 64'hFFFF_FFFF);
    check_all("post_arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
